// File: rtl/snake_pkg.sv
// Shared types and reset-placement helper for the snake playfield blocks.
// Provides coord_t, the spawn FSM state enum and the apple start-cell function.
package snake_pkg;

    localparam int GRID_BITS_DEF = 4;

    // Packed {x,y} cell coordinate at the default grid size
    typedef logic [2*GRID_BITS_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        SCAN,
        COMMIT
    } spawn_state_t;

    // Start cell of apple slot: {X0, Y0+2*slot}, X0 = 3*2^(gb-2), Y0 = 5,
    // each wrapped to the grid. Result is right-aligned {x,y}.
    function automatic logic [15:0] reset_coord(input int gb, input int slot);
        int unsigned n;
        int unsigned x0;
        int unsigned y0;
        n  = 32'd1 << gb;
        x0 = (3 * (n >> 2)) % n;
        y0 = (5 + 2 * slot) % n;
        return 16'((x0 << gb) | y0);
    endfunction

endpackage

// File: rtl/coll_edge_sync.sv
// Two-flop synchronizer for the collision level plus rising-edge pulse.
// Ports: clk_i, rst_ni (async low), clr_i (sync clear), level_i, edge_o.
module coll_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic level_i,
    output logic edge_o
);

    logic q0_q;
    logic q1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q0_q <= 1'b0;
            q1_q <= 1'b0;
        end else if (clr_i) begin
            q0_q <= 1'b0;
            q1_q <= 1'b0;
        end else begin
            q0_q <= level_i;
            q1_q <= q0_q;
        end
    end

    assign edge_o = q0_q & ~q1_q;

endmodule

// File: rtl/apple_spawner.sv
// Multi-apple placement engine: respawns eaten slots at random free cells
// and answers the display scanner's per-cell apple query.
// Ports: clk, reset (async low), s_reset (sync restart), good_coll,
//   eat_coord, rand_x, rand_y, body[], body_len, x, y in;
//   apple, apple_valid, busy, spawn_fail out.
// Option: APPLE_LFSR_EN selects an internal 16-bit LFSR as the draw source.
module apple_spawner
    import snake_pkg::*;
#(
    parameter int GRID_BITS  = 4,
    parameter int MAX_LENGTH = 32,
    parameter int N_APPLES   = 2,
    parameter int MAX_TRIES  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_reset,
    input  logic                             good_coll,
    input  logic [2*GRID_BITS-1:0]           eat_coord,
    input  logic [GRID_BITS-1:0]             rand_x,
    input  logic [GRID_BITS-1:0]             rand_y,
    input  logic [2*GRID_BITS-1:0]           body [MAX_LENGTH],
    input  logic [$clog2(MAX_LENGTH+1)-1:0]  body_len,
    input  logic [GRID_BITS-1:0]             x,
    input  logic [GRID_BITS-1:0]             y,
    output logic                             apple,
    output logic [N_APPLES-1:0]              apple_valid,
    output logic                             busy,
    output logic                             spawn_fail
);

    localparam int CW = 2 * GRID_BITS;
    localparam int LW = $clog2(MAX_LENGTH + 1);
    localparam int IW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int SW = (N_APPLES > 1) ? $clog2(N_APPLES) : 1;

    spawn_state_t         state_q;
    logic [N_APPLES-1:0]  valid_q;
    logic [N_APPLES-1:0]  valid_d;
    logic [N_APPLES-1:0]  pending_q;
    logic [N_APPLES-1:0]  pending_d;
    logic [CW-1:0]        coord_q [N_APPLES];
    logic [SW-1:0]        slot_q;
    logic [TW-1:0]        tries_q;
    logic [CW-1:0]        cand_q;
    logic [IW-1:0]        idx_q;
    logic                 apple_q;
    logic                 fail_q;

    logic                 eat_edge;
    logic [CW-1:0]        draw_c;
    logic [LW-1:0]        len_c;
    logic                 hit_apple_c;
    logic                 hit_body_c;
    logic                 scan_last_c;
    logic                 give_up_c;
    logic                 query_c;
    logic [N_APPLES-1:0]  eat_mask_c;
    logic [N_APPLES-1:0]  commit_mask_c;
    logic [SW-1:0]        pick_c;

    coll_edge_sync u_sync (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (s_reset),
        .level_i (good_coll),
        .edge_o  (eat_edge)
    );

`ifdef APPLE_LFSR_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else if (s_reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign draw_c = lfsr_q[CW-1:0];
`else
    assign draw_c = {rand_x, rand_y};
`endif

    always_comb begin
        len_c = (body_len > LW'(MAX_LENGTH)) ? LW'(MAX_LENGTH) : body_len;
        hit_apple_c = 1'b0;
        query_c     = 1'b0;
        eat_mask_c  = '0;
        pick_c      = '0;
        for (int j = 0; j < N_APPLES; j++) begin
            // The slot being respawned is invalid, so it never blocks itself
            if (valid_q[j] && j != int'(slot_q) && coord_q[j] == draw_c)
                hit_apple_c = 1'b1;
            if (valid_q[j] && coord_q[j] == {x, y})
                query_c = 1'b1;
            if (eat_edge && valid_q[j] && coord_q[j] == eat_coord)
                eat_mask_c[j] = 1'b1;
        end
        for (int j = N_APPLES - 1; j >= 0; j--) begin
            if (pending_q[j])
                pick_c = SW'(j);
        end
        hit_body_c  = (body[idx_q] == cand_q);
        scan_last_c = (int'(idx_q) + 1 >= int'(len_c));
        give_up_c   = (tries_q == TW'(MAX_TRIES - 1));
        commit_mask_c = (state_q == COMMIT) ? (N_APPLES'(1) << slot_q) : '0;
        valid_d   = (valid_q & ~eat_mask_c) | commit_mask_c;
        pending_d = (pending_q | eat_mask_c) & ~commit_mask_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            valid_q   <= '1;
            pending_q <= '0;
            slot_q    <= '0;
            tries_q   <= '0;
            cand_q    <= '0;
            idx_q     <= '0;
            apple_q   <= 1'b0;
            fail_q    <= 1'b0;
            for (int i = 0; i < N_APPLES; i++)
                coord_q[i] <= CW'(reset_coord(GRID_BITS, i));
        end else if (s_reset) begin
            state_q   <= IDLE;
            valid_q   <= '1;
            pending_q <= '0;
            slot_q    <= '0;
            tries_q   <= '0;
            cand_q    <= '0;
            idx_q     <= '0;
            apple_q   <= 1'b0;
            fail_q    <= 1'b0;
            for (int i = 0; i < N_APPLES; i++)
                coord_q[i] <= CW'(reset_coord(GRID_BITS, i));
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            apple_q   <= query_c;
            fail_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        slot_q  <= pick_c;
                        tries_q <= '0;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    cand_q <= draw_c;
                    idx_q  <= '0;
                    if (hit_apple_c) begin
                        tries_q <= tries_q + TW'(1);
                        if (give_up_c) begin
                            fail_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (len_c == '0) begin
                        state_q <= COMMIT;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_body_c) begin
                        tries_q <= tries_q + TW'(1);
                        // Out of retries: slot stays pending and is retried
                        fail_q  <= give_up_c;
                        state_q <= give_up_c ? IDLE : DRAW;
                    end else if (scan_last_c) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                COMMIT: begin
                    coord_q[slot_q] <= cand_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign apple       = apple_q;
    assign apple_valid = valid_q;
    assign busy        = (state_q != IDLE);
    assign spawn_fail  = fail_q;

endmodule
